adpll_pgm_master: RTL and testbench
===================================

# adpll_pgm_master

Programming-bus master for the ADPLL core top. Holds a shadow copy of the six ADPLL programming registers (ndiv, alpha, beta, dco_offset, dco_thresh, kdco) written by a host or controller. On command, it replays the changed entries onto the core's `pgm` / `param_sel` / `pgm_value` bus as paced, glitch-free write transactions. It shares `clk` and `clr` with the ADPLL top, so after reset both sides hold all-zero configuration.

## Interface
Parameters:
- SETUP_CYC, 1 — cycles `param_sel` / `pgm_value` are stable before `pgm` rises (legal range 1..15).
- HOLD_CYC, 1 — cycles `param_sel` / `pgm_value` are held after `pgm` falls (legal range 1..15).

Ports:
- clk  in  1 — clock.
- clr  in  1 — reset; asynchronous, active-high.
- wr_en  in  1 — host shadow write strobe.
- wr_addr  in  3 — shadow index: 0=ndiv, 1=alpha, 2=beta, 3=dco_offset, 4=dco_thresh, 5=kdco.
- wr_data  in  5 — shadow write data; index 0 keeps only bits [3:0].
- go  in  1 — start replay of dirty entries.
- go_all  in  1 — start replay of all six entries (marks all dirty).
- pgm  out  1 — programming strobe to ADPLL top.
- param_sel  out  3 — register select to ADPLL top.
- pgm_value  out  5 — data to ADPLL top.
- busy  out  1 — replay in progress.
- done  out  1 — one-cycle pulse at end of replay.
- wr_err  out  1 — one-cycle pulse for a write to index 6 or 7.
- dirty  out  6 — per-index pending flags.

## Operation
- **Shadows:** six registers (index 0 is 4 bits, the rest are 5 bits).
  - A `wr_en` write to index 0..5 updates the shadow and sets `dirty[idx]` on the next edge.
  - Index 6 or 7: no state change; `wr_err` pulses the next cycle.
  - Writes are accepted in every state, including while busy.
- **States:** IDLE, SETUP, STROBE, HOLD, DONE.
- **IDLE:**
  - `go` or `go_all` moves to SETUP when there is something to send.
  - `go_all` ORs 6'b111111 into `dirty` in the same edge.
  - If the resulting dirty set is empty, go to DONE instead.
- **SETUP entry:**
  - `cur` = lowest set dirty index.
  - Register `param_sel` = `cur`.
  - Register `pgm_value` = shadow[cur] (index 0 is zero-extended: {1'b0, ndiv}).
  - Clear the per-transaction `rewrite` flag.
  - Stay SETUP_CYC cycles, then go to STROBE.
- **STROBE:** exactly one cycle with `pgm`=1, then HOLD.
- **Dirty clearing:** `dirty[cur]` clears at the end of STROBE unless a write to `cur` occurred between SETUP entry and that edge (inclusive). In that case it stays set, and the new value is sent in a later replay.
- **HOLD:** `pgm`=0, bus held for HOLD_CYC cycles. Then:
  - SETUP for the next set dirty index above `cur`, if any;
  - otherwise DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Ordering:** indices are issued in ascending order within one replay. An index dirtied during a replay at or below `cur` waits for the next `go`.
- **Ignored commands:** `go` / `go_all` outside IDLE are ignored (not queued).
- **`clr` at any time, including mid-transaction:** all state returns to the reset values below.
  - `pgm` deasserts immediately (asynchronously).
  - Shadows are zeroed, matching the ADPLL top's own `clr`.

## Timing
- **Reset values:** `pgm`=0, `param_sel`=0, `pgm_value`=0, `busy`=0, `done`=0, `wr_err`=0, `dirty`=0, shadows=0, state=IDLE.
- **All outputs are registered:** no combinational path from inputs to `pgm` / `param_sel` / `pgm_value`.
- **Start latency:** `go` sampled at edge E gives `busy`=1 and the first `param_sel` valid from E.
- **Per-write length:** `pgm` high at E+SETUP_CYC for one cycle. One write occupies SETUP_CYC+1+HOLD_CYC cycles.
- **Replay length:** a replay of k entries takes k·(SETUP_CYC+1+HOLD_CYC) cycles of `busy`, followed by one DONE cycle (`done`=1, `busy`=0).
- **Empty go:** `done` pulses one cycle after `go`; `pgm` never rises.
- **Bus stability:** `param_sel` and `pgm_value` change only on SETUP entry. They are never changed in the cycle `pgm`=1 or in the cycle before or after it.
- **Write/clear collision:** `wr_en` to `cur` in the STROBE cycle keeps `dirty[cur]`=1 (set wins over clear).

## Test plan
- **Reset replay:** after `clr`, `go_all` with SETUP_CYC=HOLD_CYC=1 produces six `pgm` pulses 3 cycles apart on `param_sel` 0..5, each with `pgm_value`=0. `done` pulses 18 cycles after `go`, and `dirty`=0.
- **Partial replay:** write idx4=5'd17, then idx1=5'd9, then `go`. Exactly two `pgm` pulses: (`param_sel`=1, 9), then (4, 17). The ADPLL top's alpha and thresh registers read 9 and 17.
- **Write width and bad index:** write idx0=5'd31 then `go`; `pgm_value`=5'd15. Write idx6: `wr_err` pulses once and `dirty` is unchanged.
- **Rewrite collision:** during the STROBE of idx2 (value 3), write idx2=5'd20. The pulse carries 3, `dirty[2]` stays 1, and the next `go` sends 20.
- **Ignored go and empty go:** `go` while `busy` is ignored (only one `done`). `go` with `dirty`=0 gives `done` one cycle later with no `pgm`.
- **Mid-transaction reset:** `clr` asserted while `pgm`=1 drops `pgm` immediately. All outputs and `dirty` are 0, and the next `go` yields `done` only.

Source files
------------

// File: rtl/adpll_pgm_master.sv
`default_nettype none
// ============================================================================
// adpll_pgm_master
// ----------------------------------------------------------------------------
// Programming-bus master for the ADPLL core top. Keeps a shadow copy of the
// six ADPLL programming registers and, on command, replays the changed (or
// all) entries onto the core's pgm/param_sel/pgm_value bus. Each write is a
// paced transaction: bus set up, one-cycle pgm strobe, bus held.
//
// Ports:
//   clk, clr            clock; asynchronous active-high reset
//   wr_en/wr_addr/wr_data  shadow write port (index 0 keeps bits [3:0] only)
//   go                  replay dirty entries
//   go_all              mark all six dirty and replay
//   pgm/param_sel/pgm_value  programming bus to the ADPLL top (registered)
//   busy                replay in progress
//   done                one-cycle pulse at end of replay
//   wr_err              one-cycle pulse after a write to index 6 or 7
//   dirty               per-index pending flags
// Revision: 1.0
// ============================================================================
module adpll_pgm_master #(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       go,
  input  logic       go_all,
  output logic       pgm,
  output logic [2:0] param_sel,
  output logic [4:0] pgm_value,
  output logic       busy,
  output logic       done,
  output logic       wr_err,
  output logic [5:0] dirty
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] cur, cur_nxt;
  logic       rewrite, rewrite_nxt;
  logic       load;
  logic [5:0] dirty_clr, dirty_nxt;
  logic [3:0] ndiv;
  logic [4:0] alpha, beta, dco_offset, dco_thresh, kdco;
  logic [4:0] load_val;

  logic       wr_hit;
  logic       wr_cur;
  logic [5:0] wr_mask;
  logic [5:0] go_set;
  logic [5:0] above;

  function automatic logic [2:0] lowest(input logic [5:0] v);
    lowest = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  assign wr_hit  = wr_en && (wr_addr <= 3'd5);
  assign wr_cur  = wr_hit && (wr_addr == cur);
  assign wr_mask = wr_hit ? (6'b000001 << wr_addr) : 6'b000000;
  assign go_set  = dirty | (go_all ? 6'b111111 : 6'b000000);
  // Keep only indices strictly above cur. For cur=5 the shift overflows to
  // zero, the subtraction wraps to all ones and the mask correctly becomes 0.
  assign above   = dirty & ~((6'd2 << cur) - 6'd1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cur_nxt     = cur;
    rewrite_nxt = rewrite;
    load        = 1'b0;
    dirty_clr   = 6'b000000;
    case (state)
      IDLE: begin
        if (go || go_all) begin
          if (|go_set) begin
            state_nxt = SETUP;
            cur_nxt   = lowest(go_set);
            load      = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) state_nxt = STROBE;
        else                   cnt_nxt   = cnt + 4'd1;
      end
      STROBE: begin
        state_nxt = HOLD;
        cnt_nxt   = 4'd0;
        // A write to cur since SETUP entry means the strobed value is stale.
        if (!(rewrite || wr_cur)) dirty_clr[cur] = 1'b1;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          if (|above) begin
            state_nxt = SETUP;
            cur_nxt   = lowest(above);
            load      = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      cnt_nxt     = 4'd0;
      // The bus latches the pre-write shadow on this edge, so a write landing
      // on the same edge already counts as a rewrite.
      rewrite_nxt = wr_hit && (wr_addr == cur_nxt);
    end else if ((state == SETUP || state == STROBE) && wr_cur) begin
      rewrite_nxt = 1'b1;
    end

    // Set (new write) wins over clear.
    dirty_nxt = ((dirty | ((state == IDLE && go_all) ? 6'b111111 : 6'b000000))
                 & ~dirty_clr) | wr_mask;
  end

  always_comb begin
    load_val = 5'd0;
    case (cur_nxt)
      3'd0:    load_val = {1'b0, ndiv};
      3'd1:    load_val = alpha;
      3'd2:    load_val = beta;
      3'd3:    load_val = dco_offset;
      3'd4:    load_val = dco_thresh;
      3'd5:    load_val = kdco;
      default: load_val = 5'd0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt        <= 4'd0;
      cur        <= 3'd0;
      rewrite    <= 1'b0;
      dirty      <= 6'b000000;
      pgm        <= 1'b0;
      param_sel  <= 3'd0;
      pgm_value  <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
      ndiv       <= 4'd0;
      alpha      <= 5'd0;
      beta       <= 5'd0;
      dco_offset <= 5'd0;
      dco_thresh <= 5'd0;
      kdco       <= 5'd0;
    end else begin
      cnt     <= cnt_nxt;
      cur     <= cur_nxt;
      rewrite <= rewrite_nxt;
      dirty   <= dirty_nxt;
      pgm     <= (state_nxt == STROBE);
      busy    <= (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
      done    <= (state_nxt == DONE);
      wr_err  <= wr_en && (wr_addr > 3'd5);
      if (load) begin
        param_sel <= cur_nxt;
        pgm_value <= load_val;
      end
      if (wr_en) begin
        case (wr_addr)
          3'd0:    ndiv       <= wr_data[3:0];
          3'd1:    alpha      <= wr_data;
          3'd2:    beta       <= wr_data;
          3'd3:    dco_offset <= wr_data;
          3'd4:    dco_thresh <= wr_data;
          3'd5:    kdco       <= wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adpll_pgm_master.sv
`default_nettype none
// ============================================================================
// tb_adpll_pgm_master
// ----------------------------------------------------------------------------
// Self-checking bench for adpll_pgm_master. A transaction-level model keeps
// the shadow values and pending set; each replay is predicted as an ascending
// list of (cycle, index, value) strobes plus the done cycle.
// Revision: 1.0
// ============================================================================
module tb_adpll_pgm_master;

  localparam int S = 1;
  localparam int H = 1;
  localparam int P = S + 1 + H;

  logic       clk = 1'b0;
  logic       clr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic       go;
  logic       go_all;
  logic       pgm;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
  logic       busy;
  logic       done;
  logic       wr_err;
  logic [5:0] dirty;

  adpll_pgm_master #(.SETUP_CYC(S), .HOLD_CYC(H)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .go_all(go_all), .pgm(pgm), .param_sel(param_sel),
    .pgm_value(pgm_value), .busy(busy), .done(done), .wr_err(wr_err),
    .dirty(dirty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] sel;
    logic [4:0] val;
  } pulse_t;

  pulse_t     pq[$];
  int         dq[$];
  int         errs = 0;
  int         viol = 0;
  logic       ppgm = 1'b0;
  logic [2:0] psel = 3'd0;
  logic [4:0] pval = 5'd0;

  // Monitor: records strobes, done pulses, wr_err pulses, and any bus change
  // in the strobe cycle or the cycle after it.
  always @(negedge clk) begin
    if (clr) begin
      ppgm <= 1'b0;
      psel <= 3'd0;
      pval <= 5'd0;
    end else begin
      if (pgm) pq.push_back('{cyc, param_sel, pgm_value});
      if (done) dq.push_back(cyc);
      if (wr_err) errs <= errs + 1;
      if ({param_sel, pgm_value} !== {psel, pval} && (pgm || ppgm)) viol <= viol + 1;
      ppgm <= pgm;
      psel <= param_sel;
      pval <= pgm_value;
    end
  end

  // ---------------- reference model ----------------
  logic [4:0] m_sh[6];
  logic [5:0] m_dirty;
  pulse_t     exp_q[$];
  int         exp_done;

  function automatic void m_reset();
    for (int i = 0; i < 6; i++) m_sh[i] = 5'd0;
    m_dirty = 6'd0;
  endfunction

  function automatic void build_exp(input bit all, input int gc);
    int k = 0;
    exp_q.delete();
    if (all) m_dirty = 6'b111111;
    for (int i = 0; i < 6; i++) begin
      if (m_dirty[i]) begin
        exp_q.push_back('{gc + 1 + k * P + S, 3'(i), m_sh[i]});
        k++;
      end
    end
    m_dirty  = 6'd0;
    exp_done = gc + 1 + k * P;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < 6) begin
      m_sh[a]    = (a == 0) ? {1'b0, d[3:0]} : d;
      m_dirty[a] = 1'b1;
    end
  endtask

  task automatic start(input bit all, output int gc);
    gc     = cyc;
    go     = !all;
    go_all = all;
    tick();
    go     = 1'b0;
    go_all = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dq.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_replay(input bit all, output bit ok);
    int gc;
    pq.delete();
    dq.delete();
    start(all, gc);
    build_exp(all, gc);
    wait_done(200, ok);
    repeat (2) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 5'd0; go = 1'b0; go_all = 1'b0;
    repeat (3) tick();
    total++;
    if ({pgm, param_sel, pgm_value, busy, done, wr_err, dirty} !== 18'd0) begin
      bad++;
      $display("FAIL reset_outputs got pgm=%b sel=%0d val=%0d busy=%b done=%b err=%b dirty=%b want all 0",
               pgm, param_sel, pgm_value, busy, done, wr_err, dirty);
    end
    clr = 1'b0;
    m_reset();
    tick();
  endtask

  task automatic test_reset_replay();
    bit ok;
    int v0 = viol;
    run_replay(1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_replay_timeout got no done want done"); end
    total++;
    if (pq.size() != exp_q.size()) begin
      bad++; $display("FAIL reset_replay_count got %0d want %0d", pq.size(), exp_q.size());
    end
    for (int i = 0; i < pq.size() && i < exp_q.size(); i++) begin
      total++;
      if ({pq[i].c, pq[i].sel, pq[i].val} !== {exp_q[i].c, exp_q[i].sel, exp_q[i].val}) begin
        bad++;
        $display("FAIL reset_replay_pulse%0d got cyc=%0d sel=%0d val=%0d want cyc=%0d sel=%0d val=%0d",
                 i, pq[i].c, pq[i].sel, pq[i].val, exp_q[i].c, exp_q[i].sel, exp_q[i].val);
      end
    end
    total++;
    if (dq.size() != 1 || dq[0] != exp_done) begin
      bad++; $display("FAIL reset_replay_done got n=%0d cyc=%0d want cyc=%0d", dq.size(),
                      (dq.size() > 0) ? dq[0] : -1, exp_done);
    end
    total++;
    if (dirty !== 6'd0 || viol != v0) begin
      bad++; $display("FAIL reset_replay_dirty got dirty=%b viol=%0d want 0", dirty, viol - v0);
    end
  endtask

  task automatic test_partial();
    bit ok;
    wr(4, 5'd17);
    wr(1, 5'd9);
    run_replay(1'b0, ok);
    total++;
    if (!ok || pq.size() != 2) begin
      bad++; $display("FAIL partial_count got ok=%0d n=%0d want ok=1 n=2", ok, pq.size());
    end else begin
      total++;
      if ({pq[0].sel, pq[0].val, pq[1].sel, pq[1].val} !== {3'd1, 5'd9, 3'd4, 5'd17} ||
          pq[0].c != exp_q[0].c || pq[1].c != exp_q[1].c) begin
        bad++;
        $display("FAIL partial_pulses got (%0d,%0d)@%0d (%0d,%0d)@%0d want (1,9)@%0d (4,17)@%0d",
                 pq[0].sel, pq[0].val, pq[0].c, pq[1].sel, pq[1].val, pq[1].c, exp_q[0].c, exp_q[1].c);
      end
    end
    total++;
    if (dq.size() != 1 || dq[0] != exp_done) begin
      bad++; $display("FAIL partial_done got n=%0d want cyc=%0d", dq.size(), exp_done);
    end
  endtask

  task automatic test_width_bad();
    bit ok;
    int e0;
    logic [5:0] d0;
    wr(0, 5'd31);
    run_replay(1'b0, ok);
    total++;
    if (!ok || pq.size() != 1 || pq[0].sel !== 3'd0 || pq[0].val !== 5'd15) begin
      bad++; $display("FAIL width_ndiv got n=%0d val=%0d want n=1 val=15", pq.size(),
                      (pq.size() > 0) ? pq[0].val : 5'd0);
    end
    e0 = errs;
    d0 = dirty;
    wr(6, 5'd7);
    repeat (2) tick();
    total++;
    if (errs - e0 != 1 || dirty !== d0) begin
      bad++; $display("FAIL bad_index got wr_err_pulses=%0d dirty=%b want 1 dirty=%b", errs - e0, dirty, d0);
    end
  endtask

  task automatic test_collision();
    bit ok;
    bit seen = 1'b0;
    int gc;
    wr(2, 5'd3);
    pq.delete();
    dq.delete();
    start(1'b0, gc);
    for (int i = 0; i < 20; i++) begin
      if (pgm) begin seen = 1'b1; break; end
      tick();
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd20;
    tick();
    wr_en = 1'b0;
    m_sh[2]  = 5'd20;
    m_dirty  = 6'b000100;
    wait_done(50, ok);
    repeat (2) tick();
    total++;
    if (!seen || !ok || pq.size() != 1 || pq[0].val !== 5'd3 || dirty !== 6'b000100) begin
      bad++; $display("FAIL collision_first got seen=%0d n=%0d val=%0d dirty=%b want 1 1 3 000100",
                      seen, pq.size(), (pq.size() > 0) ? pq[0].val : 5'd0, dirty);
    end
    run_replay(1'b0, ok);
    total++;
    if (!ok || pq.size() != 1 || pq[0].sel !== 3'd2 || pq[0].val !== 5'd20 || dirty !== 6'd0) begin
      bad++; $display("FAIL collision_resend got n=%0d val=%0d dirty=%b want 1 20 0",
                      pq.size(), (pq.size() > 0) ? pq[0].val : 5'd0, dirty);
    end
  endtask

  task automatic test_ignored_empty();
    int gc;
    wr(3, 5'd5);
    pq.delete();
    dq.delete();
    start(1'b0, gc);
    go_all = 1'b1;
    tick();
    go_all = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (15) tick();
    total++;
    if (dq.size() != 1 || pq.size() != 1 || dirty !== 6'd0) begin
      bad++; $display("FAIL ignored_go got done=%0d pulses=%0d dirty=%b want 1 1 0", dq.size(), pq.size(), dirty);
    end
    m_dirty = 6'd0;
    pq.delete();
    dq.delete();
    start(1'b0, gc);
    repeat (5) tick();
    total++;
    if (dq.size() != 1 || pq.size() != 0 || (dq.size() > 0 && dq[0] != gc + 1)) begin
      bad++; $display("FAIL empty_go got done=%0d at %0d pulses=%0d want 1 at %0d 0",
                      dq.size(), (dq.size() > 0) ? dq[0] : -1, pq.size(), gc + 1);
    end
  endtask

  task automatic test_mid_reset();
    int gc;
    bit seen = 1'b0;
    wr(5, 5'd11);
    wr(1, 5'd4);
    start(1'b0, gc);
    for (int i = 0; i < 20; i++) begin
      if (pgm) begin seen = 1'b1; break; end
      tick();
    end
    #1 clr = 1'b1;
    #1;
    total++;
    if (!seen || pgm !== 1'b0) begin
      bad++; $display("FAIL mid_reset_async got seen=%0d pgm=%b want 1 0", seen, pgm);
    end
    tick();
    total++;
    if ({pgm, param_sel, pgm_value, busy, done, wr_err, dirty} !== 18'd0) begin
      bad++; $display("FAIL mid_reset_outputs got sel=%0d val=%0d busy=%b dirty=%b want 0",
                      param_sel, pgm_value, busy, dirty);
    end
    clr = 1'b0;
    m_reset();
    tick();
    pq.delete();
    dq.delete();
    start(1'b0, gc);
    repeat (5) tick();
    total++;
    if (dq.size() != 1 || pq.size() != 0 || (dq.size() > 0 && dq[0] != gc + 1)) begin
      bad++; $display("FAIL mid_reset_go got done=%0d pulses=%0d want 1 0", dq.size(), pq.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 12; it++) begin
      int n    = $urandom_range(0, 4);
      int nbad = 0;
      int e0   = errs;
      int v0   = viol;
      bit all  = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < n; j++) begin
        int a = $urandom_range(0, 7);
        if (a > 5) nbad++;
        wr(a, 5'($urandom));
      end
      run_replay(all, ok);
      total++;
      if (!ok || pq.size() != exp_q.size()) begin
        bad++; $display("FAIL random%0d_count got ok=%0d n=%0d want n=%0d", it, ok, pq.size(), exp_q.size());
      end
      for (int i = 0; i < pq.size() && i < exp_q.size(); i++) begin
        total++;
        if ({pq[i].c, pq[i].sel, pq[i].val} !== {exp_q[i].c, exp_q[i].sel, exp_q[i].val}) begin
          bad++;
          $display("FAIL random%0d_pulse%0d got cyc=%0d sel=%0d val=%0d want cyc=%0d sel=%0d val=%0d",
                   it, i, pq[i].c, pq[i].sel, pq[i].val, exp_q[i].c, exp_q[i].sel, exp_q[i].val);
        end
      end
      total++;
      if (dq.size() != 1 || dq[0] != exp_done || dirty !== m_dirty ||
          errs - e0 != nbad || viol != v0) begin
        bad++;
        $display("FAIL random%0d_end got done_n=%0d dirty=%b wr_err=%0d viol=%0d want done@%0d dirty=%b wr_err=%0d viol=0",
                 it, dq.size(), dirty, errs - e0, viol - v0, exp_done, m_dirty, nbad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_replay();
    test_partial();
    test_width_bad();
    test_collision();
    test_ignored_empty();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
